// File: rtl/cache_pkg.sv
// Shared definitions for the fully associative write-back cache.
//   state_t   : controller states
//   age_width : width of an LRU age field for a given line count
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    WAIT,
    RESP,
    FLUSH
  } state_t;

  // Ages run 0..n-1, so log2(n) bits; never narrower than one bit.
  function automatic int age_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_assoc_wb_if.sv
// Bus bundles for cache_assoc_wb.
//   cache_cpu_if : circuit-side request/response plus flush control.
//                  master = requesting circuit, slave = cache.
//   cache_mem_if : word-addressed memory ready/valid port.
//                  master = cache, slave = memory.
interface cache_cpu_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_hit;
  logic              flush_req;
  logic              flush_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush_req,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, flush_done
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush_req,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, flush_done
  );
endinterface

interface cache_mem_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 5
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );
  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/cache_lru_tracker.sv
// True-LRU age keeper. Age 0 = most recently used, NUM_LINES-1 = LRU.
// Ages always form a permutation of 0..NUM_LINES-1.
//   clk, rst_n : clock, async active-low reset (ages reset to age[i] = i)
//   touch_en   : mark touch_idx as most recently used this cycle
//   touch_idx  : line being touched
//   lru_idx    : line currently holding age NUM_LINES-1
//   ages       : full age vector
module cache_lru_tracker #(
  parameter int NUM_LINES = 4,
  parameter int AGE_W     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                touch_en,
  input  logic [AGE_W-1:0]                    touch_idx,
  output logic [AGE_W-1:0]                    lru_idx,
  output logic [NUM_LINES-1:0][AGE_W-1:0]     ages
);

  logic [AGE_W-1:0] touch_age;
  assign touch_age = ages[touch_idx];

  // Lines younger than the touched one age by one; the touched line
  // becomes youngest; older lines keep their age, so the set stays a
  // permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) ages[i] <= AGE_W'(i);
    end else if (touch_en) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (AGE_W'(i) == touch_idx)   ages[i] <= '0;
        else if (ages[i] < touch_age) ages[i] <= ages[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (ages[i] == AGE_W'(NUM_LINES - 1)) lru_idx = AGE_W'(i);
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// Fully associative, write-back, write-allocate cache with true-LRU
// replacement and a flush mode that writes back every dirty line.
// One word per line; the tag is the full word address.
//   clk, rst_n : clock, async active-low reset
//   cpu        : circuit request/response + flush (slave side)
//   mem        : memory ready/valid port (master side)
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 5,
  parameter int NUM_LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  cache_cpu_if.slave  cpu,
  cache_mem_if.master mem
);

  localparam int AGE_W = age_width(NUM_LINES);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } line_t;

  state_t            state, state_nx;
  line_t             lines [NUM_LINES];
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [AGE_W-1:0]  victim;
  logic [AGE_W:0]    flush_idx;   // one extra bit: counts to NUM_LINES
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_hit_q;

  logic              hit, inv_found;
  logic [AGE_W-1:0]  hit_idx, inv_idx, miss_victim, lru_idx;
  logic              touch_en;
  logic [AGE_W-1:0]  touch_idx;
  logic [NUM_LINES-1:0][AGE_W-1:0] ages;
  logic              unused_ages;
  line_t             flush_line;
  logic              flush_last, flush_wb;
  logic              m_valid, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  cache_lru_tracker #(.NUM_LINES(NUM_LINES), .AGE_W(AGE_W)) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch_en  (touch_en),
    .touch_idx (touch_idx),
    .lru_idx   (lru_idx),
    .ages      (ages)
  );

  // Only the LRU index drives replacement; the vector is for observation.
  assign unused_ages = ^ages;

  // Tag match and lowest-index invalid line (descending scan leaves the
  // lowest match in place).
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (lines[i].valid && lines[i].tag == req_addr) begin
        hit     = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!lines[i].valid) begin
        inv_found = 1'b1;
        inv_idx   = AGE_W'(i);
      end
    end
  end

  assign miss_victim = inv_found ? inv_idx : lru_idx;
  assign flush_line  = lines[flush_idx[AGE_W-1:0]];
  assign flush_last  = (flush_idx == (AGE_W+1)'(NUM_LINES));
  assign flush_wb    = !flush_last && flush_line.valid && flush_line.dirty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Memory request fields come straight from registered state, so they
  // hold steady for as long as the memory stalls.
  always_comb begin
    state_nx  = state;
    touch_en  = 1'b0;
    touch_idx = hit_idx;
    m_valid   = 1'b0;
    m_write   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    case (state)
      IDLE: begin
        if (cpu.flush_req)      state_nx = FLUSH;
        else if (cpu.req_valid) state_nx = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          touch_en = 1'b1;
          state_nx = RESP;
        end else if (lines[miss_victim].valid && lines[miss_victim].dirty) begin
          state_nx = WB;
        end else begin
          state_nx = FILL;
        end
      end
      WB: begin
        m_valid = 1'b1;
        m_write = 1'b1;
        m_addr  = lines[victim].tag;
        m_wdata = lines[victim].data;
        if (mem.mem_req_ready) state_nx = FILL;
      end
      FILL: begin
        m_valid = 1'b1;
        m_addr  = req_addr;
        if (mem.mem_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          touch_en  = 1'b1;
          touch_idx = victim;
          state_nx  = RESP;
        end
      end
      RESP: state_nx = IDLE;
      FLUSH: begin
        if (flush_last) begin
          state_nx = IDLE;
        end else if (flush_wb) begin
          m_valid = 1'b1;
          m_write = 1'b1;
          m_addr  = flush_line.tag;
          m_wdata = flush_line.data;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) lines[i] <= '0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      victim    <= '0;
      flush_idx <= '0;
      rsp_data  <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush_idx <= '0;
          if (!cpu.flush_req && cpu.req_valid) begin
            req_wr    <= cpu.req_write;
            req_addr  <= cpu.req_addr;
            req_wdata <= cpu.req_wdata;
          end
        end
        LOOKUP: begin
          rsp_hit_q <= hit;
          if (hit) begin
            if (req_wr) begin
              lines[hit_idx].data  <= req_wdata;
              lines[hit_idx].dirty <= 1'b1;
              rsp_data             <= req_wdata;
            end else begin
              rsp_data <= lines[hit_idx].data;
            end
          end else begin
            victim <= miss_victim;
          end
        end
        WB: if (mem.mem_req_ready) lines[victim].dirty <= 1'b0;
        WAIT: begin
          if (mem.mem_rsp_valid) begin
            lines[victim].valid <= 1'b1;
            lines[victim].dirty <= req_wr;
            lines[victim].tag   <= req_addr;
            lines[victim].data  <= req_wr ? req_wdata : mem.mem_rdata;
            rsp_data            <= req_wr ? req_wdata : mem.mem_rdata;
          end
        end
        FLUSH: begin
          // Clean/invalid lines advance at once; dirty ones wait for the
          // write-back handshake.
          if (!flush_last && (!flush_wb || mem.mem_req_ready)) begin
            if (flush_wb) lines[flush_idx[AGE_W-1:0]].dirty <= 1'b0;
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu.req_ready  = (state == IDLE) && !cpu.flush_req;
  assign cpu.rsp_valid  = (state == RESP);
  assign cpu.rsp_rdata  = (state == RESP) ? rsp_data : '0;
  assign cpu.rsp_hit    = (state == RESP) && rsp_hit_q;
  assign cpu.flush_done = (state == FLUSH) && flush_last;

  assign mem.mem_req_valid = m_valid;
  assign mem.mem_req_write = m_write;
  assign mem.mem_req_addr  = m_addr;
  assign mem.mem_wdata     = m_wdata;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb. The reference model treats the cache
// as a transparent memory (a shadow array holds the current value of every
// word) plus a set of resident addresses with dirty flags and a recency list
// (front = most recently used). Expected responses and expected memory
// operations are queued at issue time; a response monitor and the memory
// model pop and compare.
`timescale 1ns/1ps
module tb_cache_assoc_wb;
  localparam int ADDR_W = 7, DATA_W = 5, NUM_LINES = 4;
  localparam int WORDS  = 1 << ADDR_W;

  typedef struct { logic [DATA_W-1:0] rdata; logic hit; } rsp_t;
  typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } mop_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cache_cpu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu ();
  cache_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

  cache_assoc_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(NUM_LINES)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cpu), .mem(mem)
  );

  int checks = 0, errors = 0;
  rsp_t exp_rsp[$];
  mop_t exp_mop[$];

  // reference model state
  bit                m_valid [NUM_LINES];
  bit                m_dirty [NUM_LINES];
  logic [ADDR_W-1:0] m_tag   [NUM_LINES];
  int                recency [$];
  logic [DATA_W-1:0] shadow  [WORDS];
  logic [DATA_W-1:0] memory  [WORDS];

  // memory model knobs
  int stall_lo = 0, stall_hi = 2, lat_lo = 0, lat_hi = 3;
  int fills_seen = 0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_touch(int k);
    for (int j = 0; j < recency.size(); j++)
      if (recency[j] == k) begin recency.delete(j); break; end
    recency.push_front(k);
  endfunction

  function automatic void m_reset();
    recency.delete();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
      recency.push_back(i);
    end
    // dirty data held in the cache is lost
    for (int a = 0; a < WORDS; a++) shadow[a] = memory[a];
  endfunction

  function automatic void model_req(bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                                    output bit hit);
    int k = -1, v = -1;
    rsp_t r;
    mop_t m;
    for (int i = 0; i < NUM_LINES; i++) if (m_valid[i] && m_tag[i] == a) k = i;
    hit = (k >= 0);
    if (!hit) begin
      for (int i = NUM_LINES - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) v = recency[$];
      if (m_valid[v] && m_dirty[v]) begin
        m.wr = 1; m.addr = m_tag[v]; m.data = shadow[m_tag[v]];
        exp_mop.push_back(m);
      end
      m.wr = 0; m.addr = a; m.data = '0;
      exp_mop.push_back(m);
      m_valid[v] = 1; m_tag[v] = a; m_dirty[v] = 0;
      k = v;
    end
    if (wr) begin m_dirty[k] = 1; shadow[a] = d; end
    m_touch(k);
    r.rdata = shadow[a]; r.hit = hit;
    exp_rsp.push_back(r);
  endfunction

  function automatic void model_flush();
    mop_t m;
    for (int i = 0; i < NUM_LINES; i++)
      if (m_valid[i] && m_dirty[i]) begin
        m.wr = 1; m.addr = m_tag[i]; m.data = shadow[m_tag[i]];
        exp_mop.push_back(m);
        m_dirty[i] = 0;
      end
  endfunction

  // response monitor
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cpu.rsp_valid) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_rdata", cpu.rsp_rdata, e.rdata);
          chk("rsp_hit", cpu.rsp_hit, e.hit);
        end
      end
    end
  end

  // memory model: decides ready at the negedge; a request seen with ready=1
  // completes at the following posedge.
  initial begin : mem_model
    int stall, fcnt;
    bit pend, holding;
    logic hwr;
    logic [ADDR_W-1:0] haddr, faddr;
    logic [DATA_W-1:0] hdata;
    mop_t m;
    stall = 0; fcnt = 0; pend = 0; holding = 0;
    hwr = 0; haddr = '0; hdata = '0; faddr = '0;
    mem.mem_req_ready = 0; mem.mem_rsp_valid = 0; mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem.mem_rsp_valid = 0;
      mem.mem_rdata     = '0;
      if (!rst_n) begin
        mem.mem_req_ready = 0; pend = 0; holding = 0;
      end else begin
        if (pend) begin
          if (fcnt == 0) begin
            mem.mem_rsp_valid = 1; mem.mem_rdata = memory[faddr]; pend = 0;
          end else fcnt--;
        end
        if (mem.mem_req_valid) begin
          if (!holding) begin
            stall = $urandom_range(stall_hi, stall_lo);
            holding = 1;
            hwr = mem.mem_req_write; haddr = mem.mem_req_addr; hdata = mem.mem_wdata;
          end else begin
            chk("mem_req_stable", {mem.mem_req_write, mem.mem_req_addr, mem.mem_wdata},
                {hwr, haddr, hdata});
          end
          if (stall > 0) begin
            mem.mem_req_ready = 0; stall--;
          end else begin
            mem.mem_req_ready = 1; holding = 0;
            if (exp_mop.size() == 0) chk("mem_op_unexpected", 1, 0);
            else begin
              m = exp_mop.pop_front();
              chk("mem_op", {mem.mem_req_write, mem.mem_req_addr,
                             mem.mem_req_write ? mem.mem_wdata : '0},
                  {m.wr, m.addr, m.data});
            end
            if (mem.mem_req_write) memory[mem.mem_req_addr] = mem.mem_wdata;
            else begin
              pend = 1; faddr = mem.mem_req_addr;
              fcnt = $urandom_range(lat_hi, lat_lo); fills_seen++;
            end
          end
        end else begin
          if (holding) chk("mem_req_dropped", 0, 1);
          holding = 0;
          mem.mem_req_ready = 0;
        end
      end
    end
  end

  task automatic start_req(bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, output bit hit);
    cpu.req_valid = 1; cpu.req_write = wr; cpu.req_addr = a; cpu.req_wdata = d;
    model_req(wr, a, d, hit);
  endtask

  task automatic finish_req(bit hit);
    int cyc = 0;
    #1;
    while (!cpu.req_ready && cyc < 300) begin @(negedge clk); cyc++; end
    if (!cpu.req_ready) chk("req_accept_timeout", 0, 1);
    @(negedge clk);
    cpu.req_valid = 0;
    cyc = 1;
    while (!cpu.rsp_valid && cyc < 300) begin @(negedge clk); cyc++; end
    if (!cpu.rsp_valid) chk("rsp_timeout", 0, 1);
    else if (hit) chk("hit_latency", cyc, 2);
    @(negedge clk);
  endtask

  task automatic do_req(bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bit h;
    start_req(wr, a, d, h);
    finish_req(h);
  endtask

  task automatic do_flush();
    int cyc = 0;
    cpu.flush_req = 1;
    model_flush();
    #1 chk("flush_blocks_ready", cpu.req_ready, 0);
    @(negedge clk);
    cpu.flush_req = 0;
    while (!cpu.flush_done && cyc < 300) begin @(negedge clk); cyc++; end
    chk("flush_done", cpu.flush_done, 1);
    @(negedge clk);
    chk("flush_done_pulse", cpu.flush_done, 0);
    chk("flush_wb_drained", exp_mop.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 0; cpu.req_valid = 0; cpu.flush_req = 0;
    #1;
    chk("reset_outputs_zero",
        {cpu.rsp_valid, cpu.rsp_hit, cpu.rsp_rdata, cpu.flush_done,
         mem.mem_req_valid, mem.mem_req_write, mem.mem_req_addr, mem.mem_wdata}, 0);
    chk("reset_req_ready", cpu.req_ready, 1);
    exp_rsp.delete(); exp_mop.delete();
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", cpu.req_ready, 1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit h;
    int cyc, bad, f0;
    cpu.req_valid = 0; cpu.req_write = 0; cpu.req_addr = '0; cpu.req_wdata = '0;
    cpu.flush_req = 0;
    for (int a = 0; a < WORDS; a++) memory[a] = DATA_W'($urandom);
    memory[7'h10] = 5'h05;
    m_reset();
    #1 rst_n = 0;
    @(negedge clk);
    do_reset();

    // cold read miss then hit
    lat_lo = 2; lat_hi = 2;
    do_req(0, 7'h10, '0);
    do_req(0, 7'h10, '0);
    lat_lo = 0; lat_hi = 3;

    // LRU victim selection from a fresh cache
    @(negedge clk);
    do_reset();
    for (int a = 1; a <= 4; a++) do_req(0, ADDR_W'(a), '0);
    do_req(1, 7'h01, 5'h1F);
    do_req(0, 7'h05, '0);
    do_req(0, 7'h02, '0);

    // dirty eviction under a 4-cycle memory stall
    stall_lo = 4; stall_hi = 4;
    do_req(0, 7'h06, '0);
    do_req(0, 7'h07, '0);
    stall_lo = 0; stall_hi = 2;

    // flush with two dirty lines, then re-read them
    do_req(1, 7'h07, 5'h0C);
    do_req(1, 7'h02, 5'h13);
    do_flush();
    do_req(0, 7'h07, '0);
    do_req(0, 7'h02, '0);

    // flush and request in the same cycle
    do_req(1, 7'h05, 5'h0A);
    cpu.flush_req = 1;
    model_flush();
    start_req(0, 7'h09, '0, h);
    #1 chk("flush_priority_ready", cpu.req_ready, 0);
    @(negedge clk);
    cpu.flush_req = 0;
    cyc = 0; bad = 0;
    while (!cpu.flush_done && cyc < 300) begin
      if (cpu.req_ready) bad++;
      @(negedge clk); cyc++;
    end
    chk("ready_low_during_flush", bad, 0);
    chk("flush_done_concurrent", cpu.flush_done, 1);
    finish_req(h);

    // randomized traffic
    repeat (250) begin
      int r = $urandom_range(19, 0);
      if (r == 0) do_flush();
      else do_req(r < 8, ADDR_W'($urandom_range(11, 0)), DATA_W'($urandom));
    end

    // reset while waiting on a fill; the dirty 0x03 is lost
    do_req(1, 7'h03, 5'h15);
    lat_lo = 20; lat_hi = 20;
    f0 = fills_seen;
    start_req(0, 7'h70, '0, h);
    cyc = 0;
    while (fills_seen == f0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("fill_issued_before_reset", fills_seen - f0, 1);
    cpu.req_valid = 0;
    repeat (3) @(negedge clk);
    do_reset();
    lat_lo = 0; lat_hi = 3;
    do_req(0, 7'h03, '0);
    do_req(0, 7'h70, '0);

    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("mem_queue_empty", exp_mop.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_assoc_wb.md
Name: cache_assoc_wb

Overview:
- Parametrised, fully associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between the circuit (request/response port) and the word-addressed memory (ready/valid port).
- One memory word per line; the tag is the full address.
- Adds two things the current cache lacks: real memory handshakes (multi-cycle memory), and a flush mode that writes back every dirty line.

Parameters:
- ADDR_W, 7, address width and tag width.
- DATA_W, 5, data word width.
- NUM_LINES, 4, number of lines; must be a power of two and at least 2.
- AGE_W, $clog2(NUM_LINES), derived width of the LRU age field; not overridable.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous, active-low reset
- Req_valid  in  1  circuit request present
- Req_ready  out  1  cache accepts request this cycle
- Req_write  in  1  1 = write, 0 = read
- Req_addr  in  ADDR_W  request address
- Req_wdata  in  DATA_W  write data
- Rsp_valid  out  1  one-cycle completion pulse, no backpressure
- Rsp_rdata  out  DATA_W  read data; write data echoed for writes
- Rsp_hit  out  1  request hit a valid line
- Flush_req  in  1  start flush; sampled only in IDLE
- Flush_done  out  1  one-cycle pulse when flush completes
- Mem_req_valid  out  1  memory request
- Mem_req_ready  in  1  memory accepts request
- Mem_req_write  out  1  1 = write-back, 0 = fill read
- Mem_req_addr  out  ADDR_W  memory address
- Mem_wdata  out  DATA_W  write-back data
- Mem_rsp_valid  in  1  fill data valid
- Mem_rdata  in  DATA_W  fill data

Behaviour:
- Reset (async, Resetn=0):
  - All valid and dirty bits = 0; age[i] = i; state = IDLE.
  - All outputs 0 except Req_ready, which is 1 in IDLE.
  - Any outstanding memory transaction is abandoned. The memory model must tolerate a dropped Mem_req_valid.
- Line state: valid, dirty, tag[ADDR_W], data[DATA_W], age[AGE_W]. Ages always form a permutation of 0..NUM_LINES-1.
- LRU touch of line k (age a):
  - Every line with age < a increments.
  - Line k age = 0.
  - Other lines are unchanged.
  - Applied on every hit and every fill install.
- IDLE:
  - Req_ready = 1 when Flush_req = 0.
  - If Flush_req = 1: go to FLUSH, index = 0. Flush has priority; Req_ready = 0 that cycle.
  - Else if Req_valid = 1: capture the request, go to LOOKUP.
- LOOKUP (one cycle):
  - Hit = any line valid with tag == addr. At most one match is guaranteed by construction.
  - On hit, read: Rsp_rdata = line data.
  - On hit, write: line data = wdata, dirty = 1.
  - On hit: touch LRU, go to RESP with Rsp_hit = 1.
  - On miss, select the victim: the lowest-index invalid line; if all lines are valid, the line with age NUM_LINES-1.
  - Victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - Mem_req_valid = 1, Mem_req_write = 1, addr = victim tag, wdata = victim data.
  - Hold all three stable until Mem_req_ready = 1, then clear victim dirty and go to FILL.
- FILL:
  - Mem_req_valid = 1, Mem_req_write = 0, addr = request address.
  - Hold until Mem_req_ready = 1, then go to WAIT.
- WAIT:
  - On Mem_rsp_valid: install valid = 1 and tag = addr.
  - Read: data = Mem_rdata, dirty = 0, Rsp_rdata = Mem_rdata.
  - Write: data = wdata, dirty = 1.
  - Touch LRU, go to RESP with Rsp_hit = 0.
- RESP: Rsp_valid = 1 for exactly one cycle, then IDLE.
- Latency:
  - Hit: Rsp_valid 2 cycles after acceptance.
  - Clean miss: 2 + memory handshake cycles + fill latency.
- FLUSH:
  - For index 0..NUM_LINES-1: if the line is valid and dirty, issue a write-back as in WB, then clear dirty.
  - Clean or invalid lines are skipped in one cycle each.
  - Lines stay valid; ages are unchanged.
  - After the last index: Flush_done = 1 for one cycle, then IDLE.
- Requests are not accepted outside IDLE. Flush_req outside IDLE is ignored and is not queued.
- Mem_req_valid never deasserts before Mem_req_ready, except on reset.

Decomposition:
- Shared package cache_pkg:
  - State enum: IDLE, LOOKUP, WB, FILL, WAIT, RESP, FLUSH.
  - Line record typedef, parameterised by widths.
  - Age-width helper function.
- One sub-module: cache_lru_tracker.
  - Holds the ages.
  - Input: touch index plus enable.
  - Outputs: LRU index and the age vector.
  - Reset to age[i] = i.

Test Plan:
- Reset, then read 0x10 with memory returning 0x05 after 3 cycles → one FILL, Rsp_rdata = 0x05, Rsp_hit = 0, line 0 valid and clean. Re-read 0x10 → Rsp_valid 2 cycles after acceptance, Rsp_hit = 1, no memory traffic.
- Fill 0x01..0x04, write 0x01 with 0x1F (hit, dirty), then read 0x05 → victim is line 1 (LRU after the touch). WB is not issued because line 1 is clean; fill to line 1. Next read 0x02 → miss, evicts 0x03.
- Dirty eviction with Mem_req_ready held low for 4 cycles → Mem_req_valid, addr and wdata stable throughout; WB addr = victim tag, data = 0x1F; FILL issued after the handshake.
- Lines 0 and 2 dirty, Flush_req → exactly two write-backs, in index order; Flush_done pulse; a later read of those addresses hits and the lines are clean.
- Flush_req and Req_valid asserted in the same IDLE cycle → flush runs first; Req_ready = 0 until it completes; the request is accepted afterwards.
- Resetn pulled low during WAIT → outputs zero immediately; after release all lines are invalid and Req_ready = 1.
